// File: rtl/ram256_req_ctrl.sv
// Request sequencer in front of the 256 KiB four-bank RAM: queues read/write
// requests, issues one RAM access at a time and returns read data in order.
module ram256_req_ctrl #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned RD_LAT     = 1,
    parameter int unsigned ADDR_W     = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic                          req_we,
    input  logic [ADDR_W-1:0]             req_addr,
    input  logic [31:0]                   req_wdata,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [31:0]                   rsp_rdata,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic [ADDR_W-1:0]             ram_addr,
    output logic [31:0]                   ram_wdata,
    output logic                          ram_we,
    input  logic [31:0]                   ram_rdata
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned WCNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } req_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_e;

    req_t              mem_q [FIFO_DEPTH];
    req_t              mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    state_e            state_q, state_d;
    logic [WCNT_W-1:0] wcnt_q, wcnt_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
    logic              ram_we_q, ram_we_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;

    logic full;
    logic empty;
    logic push;
    logic pop;
    req_t head;

    // Full blocks pushes even when a pop happens in the same cycle.
    assign full  = (count_q == CNT_W'(FIFO_DEPTH));
    assign empty = (count_q == '0);
    assign push  = req_valid & ~full;
    assign pop   = (state_q == S_IDLE) & ~empty;
    assign head  = mem_q[rd_ptr_q];

    assign req_ready  = rst_n & ~full;
    assign fifo_count = count_q;
    assign ram_addr   = ram_addr_q;
    assign ram_wdata  = ram_wdata_q;
    assign ram_we     = ram_we_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_rdata  = rsp_rdata_q;

    // Request FIFO bookkeeping.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q].we    = req_we;
            mem_d[wr_ptr_q].addr  = req_addr;
            mem_d[wr_ptr_q].wdata = req_wdata;
            wr_ptr_d              = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Access sequencer: one outstanding RAM access at a time.
    always_comb begin
        state_d     = state_q;
        wcnt_d      = wcnt_q;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        ram_we_d    = 1'b0;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    ram_addr_d  = head.addr;
                    ram_wdata_d = head.wdata;
                    ram_we_d    = head.we;
                    state_d     = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (ram_we_q) begin
                    state_d = S_IDLE;
                end else begin
                    wcnt_d  = WCNT_W'(RD_LAT - 1);
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (wcnt_q == '0) begin
                    rsp_rdata_d = ram_rdata;
                    rsp_valid_d = 1'b1;
                    state_d     = S_RESP;
                end else begin
                    wcnt_d = wcnt_q - WCNT_W'(1);
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            state_q     <= S_IDLE;
            wcnt_q      <= '0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            ram_we_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            state_q     <= state_d;
            wcnt_q      <= wcnt_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            ram_we_q    <= ram_we_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

endmodule

// File: doc/ram256_req_ctrl.md
Name: ram256_req_ctrl

Overview:
- Request sequencer that sits directly upstream of the 256 KiB four-bank RAM (16-bit address, 32-bit data).
- Accepts read and write requests from a master over a valid/ready handshake and buffers them in a small FIFO.
- Drives the RAM's addr16/dataIn/wrEnable inputs one access at a time and captures RAM dataOut after the read latency.
- Returns read data over a valid/ready response channel, strictly in request order.

Parameters:
- FIFO_DEPTH, 4, request FIFO entries (power of 2, ≥2).
- RD_LAT, 1, clock cycles from address sampled by RAM until its dataOut is valid.
- ADDR_W, 16, request/RAM address width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  master presents a request.
- req_ready  out  1  controller can accept; equals !fifo_full, forced 0 while rst_n=0.
- req_we  in  1  0: read, 1: write.
- req_addr  in  ADDR_W  request address.
- req_wdata  in  32  write data (ignored for reads).
- rsp_valid  out  1  read data available.
- rsp_ready  in  1  master accepts response.
- rsp_rdata  out  32  read data.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  occupied FIFO entries.
- ram_addr  out  ADDR_W  to RAM addr16.
- ram_wdata  out  32  to RAM dataIn.
- ram_we  out  1  to RAM wrEnable.
- ram_rdata  in  32  from RAM dataOut.

Behaviour:
- Reset (async assert, sync release): FIFO empty, fifo_count=0, FSM=IDLE, ram_addr=0, ram_wdata=0, ram_we=0, rsp_valid=0, rsp_rdata=0.
- Push: req_valid && req_ready at an edge → entry {we, addr, wdata} written at tail.
- Full FIFO: req_ready=0 even if a pop occurs in the same cycle.
- Push and pop in the same cycle: count unchanged.
- Pointers wrap modulo FIFO_DEPTH.
- All RAM-side outputs and rsp_* are registered.
- FSM states:
  - IDLE: if FIFO non-empty, pop head, load ram_addr/ram_wdata, set ram_we=head.we → ISSUE. Otherwise ram_we=0 and stay.
  - ISSUE (1 cycle, ram_we reflects the request):
    - Write → clear ram_we → IDLE.
    - Read → ram_we=0, load wait counter with RD_LAT-1 → WAIT.
  - WAIT: decrement counter each cycle. At 0, capture ram_rdata into rsp_rdata, set rsp_valid=1 → RESP.
  - RESP: hold rsp_valid and rsp_rdata stable until rsp_ready=1 at an edge. Then rsp_valid=0 → IDLE.
- Timing:
  - ram_we is high for exactly one cycle per write and never high for reads.
  - ram_addr holds its value outside IDLE→ISSUE loads.
  - Request accepted at edge E0 into an empty FIFO with FSM idle:
    - RAM signals valid after E1.
    - Read response valid after E(2+RD_LAT), i.e. 3 cycles for RD_LAT=1.
  - Write throughput: one write per 2 cycles.
- Ordering: one outstanding access. A read blocks later requests (which still queue in the FIFO) until its response is accepted, so read-after-write to the same address returns the new data.
- rsp_ready held high: rsp_valid is high for exactly one cycle per read.
- rst_n asserted mid-operation: queued and in-flight requests are discarded, ram_we drops to 0 immediately, and rsp_valid drops to 0 immediately.
- Address passes through unmodified; the RAM decodes bank bits [15:14].

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with req_valid=1 → req_ready=0, ram_we=0, rsp_valid=0, fifo_count=0. After release, req_ready=1.
- Write then read: write addr 0x4010 data 0xDEADBEEF, then read 0x4010 → ram_we pulses 1 cycle with ram_addr=0x4010; rsp_rdata=0xDEADBEEF valid 3 cycles after the read is accepted (RD_LAT=1).
- Bank span: write 0x0001/0x4001/0x8001/0xC001 with data 1/2/3/4, then read all four → responses 1,2,3,4 in order; ram_addr[15:14] seen as 0,1,2,3.
- FIFO full: rsp_ready=0, issue 1 read + 5 writes back-to-back → req_ready drops after the FIFO holds 4; fifo_count=4; no ram_we while the read response is unaccepted. Raise rsp_ready → writes drain at one per 2 cycles.
- Response backpressure: read 0x0002 (holding 0x55AA55AA) with rsp_ready=0 for 5 cycles → rsp_valid and rsp_rdata stay 0x55AA55AA; deassert exactly one cycle after rsp_ready=1.
- Mid-op reset: assert rst_n=0 during WAIT with 2 writes queued → after release fifo_count=0, no ram_we pulse occurs, and no rsp_valid occurs.
